// File: rtl/hazard_controller.sv
// Load-use stall, branch/jump flush and data-memory freeze sequencing for the 5-stage MIPS pipeline.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_memRead,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t state, state_next;

    logic mw;
    logic lu;
    logic br;
    logic lu_act;

    // mem_req/mem_ready: an access is in flight while mem_req is high and completes in the
    // first cycle where mem_ready is also high; every cycle before that freezes the pipeline.
    assign mw = mem_req && !mem_ready;
    assign lu = id_ex_memRead && (id_ex_rt != 5'd0) &&
                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    assign br = branch_taken || jump;

    // The bubble already sits in EX during LOAD_STALL, so a match there is stale.
    assign lu_act = lu && (state != LOAD_STALL);

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_next   = RUN;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            state_next   = RUN;
        end else if (mw) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_next   = MEM_WAIT;
        end else if (lu_act) begin
            // A branch arriving with the stall stays held in ID and is re-evaluated next cycle.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            state_next   = LOAD_STALL;
        end else if (br) begin
            if_id_flush  = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (if_id_flush && (flush_q != {CNT_W{1'b1}})) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; counter expectations follow HAZARD_STATS_EN.
module tb_hazard_controller;

    localparam int CNT_W = 4;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [5:0] O_NORM   = 6'b110011;
    localparam logic [5:0] O_STALL  = 6'b000111;
    localparam logic [5:0] O_FLUSH  = 6'b111011;
    localparam logic [5:0] O_FREEZE = 6'b000000;
    localparam logic [5:0] O_RESET  = 6'b001100;

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LS   = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;

    logic             clk;
    logic             rst;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic [4:0]       id_ex_rt;
    logic             id_ex_memRead;
    logic             branch_taken;
    logic             jump;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       state_dbg;
    logic [5:0]       outs;

    int n_checks = 0;
    int n_pass   = 0;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_id_rs     (if_id_rs),
        .if_id_rt     (if_id_rt),
        .id_ex_rt     (id_ex_rt),
        .id_ex_memRead(id_ex_memRead),
        .branch_taken (branch_taken),
        .jump         (jump),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_write (ex_mem_write),
        .mem_wb_write (mem_wb_write),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [CNT_W-1:0] exp_cnt(input int v);
        return STATS ? CNT_W'(v) : '0;
    endfunction

    // driver tasks: each call starts a new cycle at the falling edge, outputs settle 1 time unit later
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                         input logic mrd, input logic bt, input logic jp,
                         input logic mq, input logic mrdy);
        @(negedge clk);
        rst           = 1'b0;
        if_id_rs      = rs;
        if_id_rt      = rt;
        id_ex_rt      = ex_rt;
        id_ex_memRead = mrd;
        branch_taken  = bt;
        jump          = jp;
        mem_req       = mq;
        mem_ready     = mrdy;
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (outs !== O_RESET) $display("FAIL reset_outs cyc%0d got %b exp %b", i, outs, O_RESET);
            else n_pass++;
            if (i == 0) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
            end
        end
        idle();
        n_checks++;
        if (outs !== O_NORM) $display("FAIL reset_release_outs got %b exp %b", outs, O_NORM);
        else n_pass++;
        n_checks++;
        if (state_dbg !== S_RUN) $display("FAIL reset_state got %0d exp %0d", state_dbg, S_RUN);
        else n_pass++;
        n_checks++;
        if (stall_cycles !== exp_cnt(0) || flush_count !== exp_cnt(0))
            $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count);
        else n_pass++;
    endtask

    task automatic test_load_use();
        pulse_reset();
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_STALL) $display("FAIL lu_stall got %b exp %b", outs, O_STALL);
        else n_pass++;
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM) $display("FAIL lu_second got %b exp %b", outs, O_NORM);
        else n_pass++;
        n_checks++;
        if (state_dbg !== S_LS) $display("FAIL lu_state got %0d exp %0d", state_dbg, S_LS);
        else n_pass++;
        idle();
        n_checks++;
        if (stall_cycles !== exp_cnt(1)) $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cycles, exp_cnt(1));
        else n_pass++;
        n_checks++;
        if (state_dbg !== S_RUN) $display("FAIL lu_back_run got %0d exp %0d", state_dbg, S_RUN);
        else n_pass++;
    endtask

    task automatic test_reg_zero();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM) $display("FAIL reg_zero got %b exp %b", outs, O_NORM);
        else n_pass++;
        drive(5'd4, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM) $display("FAIL no_load got %b exp %b", outs, O_NORM);
        else n_pass++;
        drive(5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_STALL) $display("FAIL lu_rt_match got %b exp %b", outs, O_STALL);
        else n_pass++;
        idle();
    endtask

    task automatic test_branch_vs_stall();
        pulse_reset();
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_STALL) $display("FAIL br_lu_stall got %b exp %b", outs, O_STALL);
        else n_pass++;
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_FLUSH) $display("FAIL br_held_flush got %b exp %b", outs, O_FLUSH);
        else n_pass++;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_FLUSH) $display("FAIL jump_flush got %b exp %b", outs, O_FLUSH);
        else n_pass++;
        n_checks++;
        if (flush_count !== exp_cnt(1)) $display("FAIL flush_cnt1 got %0d exp %0d", flush_count, exp_cnt(1));
        else n_pass++;
        idle();
        n_checks++;
        if (flush_count !== exp_cnt(2) || stall_cycles !== exp_cnt(1))
            $display("FAIL br_counters got %0d/%0d exp %0d/%0d", flush_count, stall_cycles, exp_cnt(2), exp_cnt(1));
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (outs !== O_FREEZE) $display("FAIL mw_freeze cyc%0d got %b exp %b", i, outs, O_FREEZE);
            else n_pass++;
        end
        n_checks++;
        if (state_dbg !== S_MW) $display("FAIL mw_state got %0d exp %0d", state_dbg, S_MW);
        else n_pass++;
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (outs !== O_STALL) $display("FAIL mw_ready_lu got %b exp %b", outs, O_STALL);
        else n_pass++;
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (outs !== O_NORM || state_dbg !== S_LS)
            $display("FAIL mw_after_stall got %b/%0d exp %b/%0d", outs, state_dbg, O_NORM, S_LS);
        else n_pass++;
        idle();
        n_checks++;
        if (stall_cycles !== exp_cnt(4)) $display("FAIL mw_stall_cnt got %0d exp %0d", stall_cycles, exp_cnt(4));
        else n_pass++;
        // freeze arriving in LOAD_STALL, then reset aborting MEM_WAIT
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (outs !== O_FREEZE) $display("FAIL ls_to_mw got %b exp %b", outs, O_FREEZE);
        else n_pass++;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs !== O_RESET || state_dbg !== S_MW)
            $display("FAIL mw_reset got %b/%0d exp %b/%0d", outs, state_dbg, O_RESET, S_MW);
        else n_pass++;
        idle();
        n_checks++;
        if (outs !== O_NORM || state_dbg !== S_RUN || stall_cycles !== exp_cnt(0))
            $display("FAIL mw_abort got %b/%0d/%0d exp %b/%0d/%0d", outs, state_dbg, stall_cycles,
                     O_NORM, S_RUN, exp_cnt(0));
        else n_pass++;
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 10; i++) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (stall_cycles !== exp_cnt(9)) $display("FAIL sat_mid got %0d exp %0d", stall_cycles, exp_cnt(9));
        else n_pass++;
        for (int i = 0; i < 10; i++) drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        n_checks++;
        if (stall_cycles !== exp_cnt(15)) $display("FAIL sat_stop got %0d exp %0d", stall_cycles, exp_cnt(15));
        else n_pass++;
        n_checks++;
        if (flush_count !== exp_cnt(0)) $display("FAIL sat_flush got %0d exp %0d", flush_count, exp_cnt(0));
        else n_pass++;
    endtask

    initial begin
        rst           = 1'b1;
        if_id_rs      = '0;
        if_id_rt      = '0;
        id_ex_rt      = '0;
        id_ex_memRead = 1'b0;
        branch_taken  = 1'b0;
        jump          = 1'b0;
        mem_req       = 1'b0;
        mem_ready     = 1'b0;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch_vs_stall();
        test_mem_wait();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
